msi_snoop_bus: RTL and testbench

MSI_SNOOP_BUS -- requirements
Module: msi_snoop_bus

---
 rtl/msi_snoop_bus.sv | 163 ++++++++++++++++
 tb/tb_msi_snoop_bus.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_snoop_bus.sv
// Snooping bus controller for MSI caches: round-robin arbitration, one snoop broadcast
// per transaction, then either a memory read, a flush write-back, or nothing (upgrade).
module msi_snoop_bus #(
    parameter int NUM_PROCS       = 4,
    parameter int ADDR_SIZE       = 32,
    parameter int CACHE_LINE_SIZE = 128
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_PROCS-1:0]                 req_i,
    input  logic [2*NUM_PROCS-1:0]               msg_i,
    input  logic [ADDR_SIZE*NUM_PROCS-1:0]       addr_i,
    output logic [NUM_PROCS-1:0]                 gnt_o,
    output logic                                 bus_valid_o,
    output logic [1:0]                           bus_msg_o,
    output logic [ADDR_SIZE-1:0]                 bus_addr_o,
    input  logic [NUM_PROCS-1:0]                 flush_i,
    input  logic [CACHE_LINE_SIZE*NUM_PROCS-1:0] flush_data_i,
    output logic [CACHE_LINE_SIZE-1:0]           data_o,
    output logic                                 data_valid_o,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [ADDR_SIZE-1:0]                 mem_addr_o,
    output logic [CACHE_LINE_SIZE-1:0]           mem_wdata_o,
    input  logic [CACHE_LINE_SIZE-1:0]           mem_rdata_i,
    input  logic                                 mem_ack_i
);
    localparam int PW = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1;

    typedef enum logic [2:0] {IDLE, SNOOP, MEM, FLUSH, DONE} state_t;

    state_t                     state, state_nxt;
    logic [PW-1:0]              ptr;
    logic [PW-1:0]              win_idx;
    logic [PW-1:0]              fl_idx;
    logic [PW-1:0]              cidx;
    logic                       win_found;
    logic                       fl_found;
    int                         cand;
    logic [NUM_PROCS-1:0]       gnt_q;
    logic [NUM_PROCS-1:0]       flush_masked;
    logic [1:0]                 msg_q;
    logic [ADDR_SIZE-1:0]       addr_q;
    logic [CACHE_LINE_SIZE-1:0] flush_q;
    logic [CACHE_LINE_SIZE-1:0] data_q;
    logic                       no_data;

    // BusUpgr (10) and reserved (11) both carry no line data
    assign no_data = msg_q[1];

    // Round-robin search starting at ptr, wrapping at NUM_PROCS
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cidx      = '0;
        for (int off = 0; off < NUM_PROCS; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_PROCS) cand = cand - NUM_PROCS;
            cidx = PW'(cand);
            if (!win_found && req_i[cidx]) begin
                win_found = 1'b1;
                win_idx   = cidx;
            end
        end
    end

    // The owner never supplies its own line; lowest remaining index wins
    assign flush_masked = flush_i & ~gnt_q;

    always_comb begin
        fl_found = 1'b0;
        fl_idx   = '0;
        for (int i = NUM_PROCS - 1; i >= 0; i--) begin
            if (flush_masked[i]) begin
                fl_found = 1'b1;
                fl_idx   = PW'(i);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        bus_valid_o  = 1'b0;
        bus_msg_o    = '0;
        bus_addr_o   = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        data_valid_o = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) state_nxt = SNOOP;
            end
            SNOOP: begin
                bus_valid_o = 1'b1;
                bus_msg_o   = msg_q;
                bus_addr_o  = addr_q;
                if (no_data)       state_nxt = DONE;
                else if (fl_found) state_nxt = FLUSH;
                else               state_nxt = MEM;
            end
            MEM: begin
                mem_req_o  = 1'b1;
                mem_addr_o = addr_q;
                if (mem_ack_i) state_nxt = DONE;
            end
            FLUSH: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = flush_q;
                if (mem_ack_i) state_nxt = DONE;
            end
            DONE: begin
                data_valid_o = !no_data;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_q   <= '0;
            msg_q   <= '0;
            addr_q  <= '0;
            flush_q <= '0;
            data_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt_q  <= NUM_PROCS'(1) << win_idx;
                        ptr    <= (win_idx == PW'(NUM_PROCS - 1)) ? '0 : win_idx + 1'b1;
                        msg_q  <= msg_i[2*int'(win_idx) +: 2];
                        addr_q <= addr_i[ADDR_SIZE*int'(win_idx) +: ADDR_SIZE];
                    end
                end
                SNOOP: begin
                    if (fl_found) flush_q <= flush_data_i[CACHE_LINE_SIZE*int'(fl_idx) +: CACHE_LINE_SIZE];
                end
                MEM: begin
                    if (mem_ack_i) data_q <= mem_rdata_i;
                end
                FLUSH: begin
                    if (mem_ack_i) data_q <= flush_q;
                end
                DONE: begin
                    gnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign gnt_o  = gnt_q;
    assign data_o = data_q;
endmodule

// File: tb/tb_msi_snoop_bus.sv
// Scoreboard bench for msi_snoop_bus: stimulus pushes expected snoop/memory/data events,
// monitors pop and compare them as the DUT presents them.
module tb_msi_snoop_bus;
    localparam int NP = 4;
    localparam int AW = 32;
    localparam int LW = 128;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req = '0;
    logic [2*NP-1:0] msg = '0;
    logic [AW*NP-1:0] addr = '0;
    logic [NP-1:0]   flush = '0;
    logic [LW*NP-1:0] flush_data = '0;
    logic [NP-1:0]   gnt;
    logic            bus_valid;
    logic [1:0]      bus_msg;
    logic [AW-1:0]   bus_addr;
    logic [LW-1:0]   data;
    logic            data_valid;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [LW-1:0]   mem_wdata;
    logic [LW-1:0]   mem_rdata;
    logic            mem_ack = 1'b0;

    logic [7:0]      req8 = '0;
    logic [15:0]     msg8 = {8{2'b10}};
    logic [AW*8-1:0] addr8 = '0;
    logic [7:0]      flush8 = '0;
    logic [LW*8-1:0] flush_data8 = '0;
    logic [7:0]      gnt8;
    logic            bus_valid8;
    logic [1:0]      bus_msg8;
    logic [AW-1:0]   bus_addr8;
    logic [LW-1:0]   data8;
    logic            data_valid8;
    logic            mem_req8;
    logic            mem_we8;
    logic [AW-1:0]   mem_addr8;
    logic [LW-1:0]   mem_wdata8;
    logic [LW-1:0]   mem_rdata8 = '0;
    logic            mem_ack8 = 1'b0;

    always #5 clk = ~clk;

    msi_snoop_bus #(.NUM_PROCS(NP), .ADDR_SIZE(AW), .CACHE_LINE_SIZE(LW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .msg_i(msg), .addr_i(addr), .gnt_o(gnt),
        .bus_valid_o(bus_valid), .bus_msg_o(bus_msg), .bus_addr_o(bus_addr),
        .flush_i(flush), .flush_data_i(flush_data), .data_o(data), .data_valid_o(data_valid),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    msi_snoop_bus #(.NUM_PROCS(8), .ADDR_SIZE(AW), .CACHE_LINE_SIZE(LW)) dut8 (
        .clk_i(clk), .rst_i(rst), .req_i(req8), .msg_i(msg8), .addr_i(addr8), .gnt_o(gnt8),
        .bus_valid_o(bus_valid8), .bus_msg_o(bus_msg8), .bus_addr_o(bus_addr8),
        .flush_i(flush8), .flush_data_i(flush_data8), .data_o(data8), .data_valid_o(data_valid8),
        .mem_req_o(mem_req8), .mem_we_o(mem_we8), .mem_addr_o(mem_addr8), .mem_wdata_o(mem_wdata8),
        .mem_rdata_i(mem_rdata8), .mem_ack_i(mem_ack8)
    );

    // Memory returns a line derived from the address it was asked for
    function automatic logic [LW-1:0] rd_model(input logic [AW-1:0] a);
        return {4{a ^ 32'hCAFE_0000}};
    endfunction

    assign mem_rdata = rd_model(mem_addr);

    typedef struct packed {
        logic [NP-1:0] gnt;
        logic [1:0]    msg;
        logic [AW-1:0] addr;
    } snp_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } mem_t;

    snp_t          snp_q[$];
    mem_t          mem_q[$];
    logic [LW-1:0] dat_q[$];
    logic [7:0]    g8_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_delay = 1;
    int ack_cnt = 0;
    int snoop_cyc = 0;
    int mem_cyc = 0;
    int data_cyc = 0;
    int c0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_agent(input int i, input logic [1:0] m, input logic [AW-1:0] a,
                             input logic [LW-1:0] fd);
        msg[i*2 +: 2]         = m;
        addr[i*AW +: AW]      = a;
        flush_data[i*LW +: LW] = fd;
    endtask

    task automatic exp_snoop(input logic [NP-1:0] g, input logic [1:0] m, input logic [AW-1:0] a);
        snp_t s;
        s.gnt = g; s.msg = m; s.addr = a;
        snp_q.push_back(s);
    endtask

    task automatic exp_mem(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        mem_t e;
        e.we = we; e.addr = a; e.wdata = wd;
        mem_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input int budget);
        int n;
        n = 0;
        while ((snp_q.size() + mem_q.size() + dat_q.size()) != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if ((snp_q.size() + mem_q.size() + dat_q.size()) != 0) begin
            chk("drain_timeout", LW'(snp_q.size() + mem_q.size() + dat_q.size()), '0);
            snp_q.delete(); mem_q.delete(); dat_q.delete();
        end
    endtask

    // Memory responder: ack after ack_delay extra cycles of a held request
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                mem_ack = (ack_cnt == ack_delay);
                ack_cnt++;
            end else begin
                mem_ack = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    // Monitor for the 4-agent instance
    initial begin
        snp_t          se;
        mem_t          me;
        logic [LW-1:0] de;
        logic          mem_req_prev;
        mem_req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_req_prev = 1'b0;
            end else begin
                if (bus_valid) begin
                    if (snp_q.size() == 0) chk("unexpected_snoop", LW'(bus_valid), '0);
                    else begin
                        se = snp_q.pop_front();
                        chk("snoop_gnt", LW'(gnt), LW'(se.gnt));
                        chk("snoop_msg", LW'(bus_msg), LW'(se.msg));
                        chk("snoop_addr", LW'(bus_addr), LW'(se.addr));
                        snoop_cyc = cyc;
                    end
                end
                if (mem_req && !mem_req_prev) begin
                    if (mem_q.size() == 0) chk("unexpected_mem_req", LW'(mem_req), '0);
                    else begin
                        me = mem_q.pop_front();
                        chk("mem_we", LW'(mem_we), LW'(me.we));
                        chk("mem_addr", LW'(mem_addr), LW'(me.addr));
                        if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
                        mem_cyc = cyc;
                    end
                end
                mem_req_prev = mem_req;
                if (data_valid) begin
                    if (dat_q.size() == 0) chk("unexpected_data_valid", LW'(data_valid), '0);
                    else begin
                        de = dat_q.pop_front();
                        chk("data_o", data, de);
                        data_cyc = cyc;
                    end
                end
            end
        end
    end

    // Monitor for the 8-agent instance (grant order only)
    initial begin
        logic [7:0] ge;
        forever begin
            @(negedge clk);
            if (!rst && bus_valid8) begin
                if (g8_q.size() == 0) chk("unexpected_snoop8", LW'(bus_valid8), '0);
                else begin
                    ge = g8_q.pop_front();
                    chk("snoop8_gnt", LW'(gnt8), LW'(ge));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int ord[5];
        logic [AW-1:0] a;
        int n;
        ord = '{0, 1, 2, 3, 0};

        #1;
        chk("rst_gnt", LW'(gnt), '0);
        chk("rst_bus_valid", LW'(bus_valid), '0);
        chk("rst_mem_req", LW'(mem_req), '0);
        chk("rst_data_valid", LW'(data_valid), '0);
        chk("rst_data", data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // All agents request BusRd continuously: grants rotate 0,1,2,3,0
        for (int i = 0; i < NP; i++) set_agent(i, 2'b00, 32'h1000 + 32'(i) * 32'h40, '0);
        for (int k = 0; k < 5; k++) begin
            a = 32'h1000 + 32'(ord[k]) * 32'h40;
            exp_snoop(NP'(1) << ord[k], 2'b00, a);
            exp_mem(1'b0, a, '0);
            dat_q.push_back(rd_model(a));
        end
        ack_delay = 1;
        req = 4'b1111;
        wait_drained(100);
        req = '0;
        idle(3);

        // Agent 1 BusRd 0x100, agent 3 supplies 0xDEAD: write-back, no read
        set_agent(1, 2'b00, 32'h100, '0);
        set_agent(3, 2'b00, 32'h0, 128'hDEAD);
        exp_snoop(4'b0010, 2'b00, 32'h100);
        exp_mem(1'b1, 32'h100, 128'hDEAD);
        dat_q.push_back(128'hDEAD);
        flush = 4'b1000;
        req = 4'b0010;
        wait_drained(40);
        req = '0;
        flush = '0;
        idle(3);

        // Agent 2 BusUpgr: snoop only, no memory, no data_valid
        set_agent(2, 2'b10, 32'h200, '0);
        exp_snoop(4'b0100, 2'b10, 32'h200);
        req = 4'b0100;
        wait_drained(40);
        req = '0;
        idle(4);

        // Agent 1 BusRdX; agents 0,1,2 flush: agent 0 data used
        set_agent(0, 2'b00, 32'h0, 128'hA0);
        set_agent(1, 2'b01, 32'h300, 128'hA1);
        set_agent(2, 2'b00, 32'h0, 128'hA2);
        exp_snoop(4'b0010, 2'b01, 32'h300);
        exp_mem(1'b1, 32'h300, 128'hA0);
        dat_q.push_back(128'hA0);
        flush = 4'b0111;
        req = 4'b0010;
        wait_drained(40);
        req = '0;
        flush = '0;
        idle(3);

        // Owner 0 also asserts flush: its bit is masked, agent 2 supplies
        set_agent(0, 2'b00, 32'h380, 128'hB0);
        set_agent(2, 2'b00, 32'h0, 128'hB2);
        exp_snoop(4'b0001, 2'b00, 32'h380);
        exp_mem(1'b1, 32'h380, 128'hB2);
        dat_q.push_back(128'hB2);
        flush = 4'b0101;
        req = 4'b0001;
        wait_drained(40);
        req = '0;
        flush = '0;
        idle(3);

        // Reserved message from agent 3 behaves like an upgrade
        set_agent(3, 2'b11, 32'h2C0, '0);
        exp_snoop(4'b1000, 2'b11, 32'h2C0);
        req = 4'b1000;
        wait_drained(40);
        req = '0;
        idle(4);

        // Latency on an idle bus with ack in the first memory cycle
        set_agent(0, 2'b00, 32'h400, '0);
        exp_snoop(4'b0001, 2'b00, 32'h400);
        exp_mem(1'b0, 32'h400, '0);
        dat_q.push_back(rd_model(32'h400));
        ack_delay = 0;
        c0 = cyc;
        req = 4'b0001;
        wait_drained(40);
        req = '0;
        chk("lat_snoop", LW'(snoop_cyc - c0), LW'(1));
        chk("lat_mem", LW'(mem_cyc - c0), LW'(2));
        chk("lat_data", LW'(data_cyc - c0), LW'(3));
        idle(3);

        // Reset while MEM waits for an ack
        set_agent(2, 2'b00, 32'h500, '0);
        exp_snoop(4'b0100, 2'b00, 32'h500);
        exp_mem(1'b0, 32'h500, '0);
        ack_delay = 50;
        req = 4'b0100;
        wait_drained(40);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_gnt", LW'(gnt), '0);
        chk("arst_mem_req", LW'(mem_req), '0);
        chk("arst_mem_addr", LW'(mem_addr), '0);
        chk("arst_bus_valid", LW'(bus_valid), '0);
        chk("arst_data_valid", LW'(data_valid), '0);
        chk("arst_data", data, '0);
        req = '0;
        idle(2);
        rst = 1'b0;
        idle(1);

        // After reset ptr is 0: agent 1 before agent 3
        set_agent(1, 2'b00, 32'h600, '0);
        set_agent(3, 2'b10, 32'h700, '0);
        exp_snoop(4'b0010, 2'b00, 32'h600);
        exp_mem(1'b0, 32'h600, '0);
        dat_q.push_back(rd_model(32'h600));
        exp_snoop(4'b1000, 2'b10, 32'h700);
        ack_delay = 1;
        req = 4'b1010;
        wait_drained(60);
        req = '0;
        idle(4);

        // Eight agents: grant 6 moves ptr to 7, then 7 wins over 0
        g8_q.push_back(8'h40);
        req8 = 8'h40;
        n = 0;
        while (g8_q.size() != 0 && n < 40) begin @(posedge clk); #2; n++; end
        req8 = '0;
        idle(4);
        g8_q.push_back(8'h80);
        g8_q.push_back(8'h01);
        req8 = 8'h81;
        n = 0;
        while (g8_q.size() != 0 && n < 40) begin @(posedge clk); #2; n++; end
        req8 = '0;
        idle(4);

        chk("snp_q_left", LW'(snp_q.size()), '0);
        chk("mem_q_left", LW'(mem_q.size()), '0);
        chk("dat_q_left", LW'(dat_q.size()), '0);
        chk("g8_q_left", LW'(g8_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
